// File: rtl/keccak_chi_compress_if.sv
// Handshake/data bundle between the chi S-box expansion and the compression stage.
// The master modport is the producer/consumer side; the slave modport is keccak_chi_compress.
interface keccak_chi_compress_if #(
  parameter int d = 5
);
  localparam int NE = (d + 1) * (d + 1);
  localparam int NC = d + 1;

  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [NE-1:0] ap_i;
  logic [NE-1:0] bp_i;
  logic [NE-1:0] cp_i;
  logic [NE-1:0] dp_i;
  logic [NE-1:0] ep_i;

  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [NC-1:0] a_o;
  logic [NC-1:0] b_o;
  logic [NC-1:0] c_o;
  logic [NC-1:0] d_o;
  logic [NC-1:0] e_o;

  modport master (
    output in_valid, in_last, ap_i, bp_i, cp_i, dp_i, ep_i, out_ready,
    input  in_ready, out_valid, out_last, a_o, b_o, c_o, d_o, e_o
  );

  modport slave (
    input  in_valid, in_last, ap_i, bp_i, cp_i, dp_i, ep_i, out_ready,
    output in_ready, out_valid, out_last, a_o, b_o, c_o, d_o, e_o
  );
endinterface

// File: rtl/keccak_chi_compress.sv
// Masked Keccak chi compression: S1 registers (d+1)^2 expanded shares per bit as a glitch
// barrier, S2 XOR-folds them to d+1 shares. Optional macro: KECCAK_CLR_AFTER_USE_EN.
module keccak_chi_compress #(
  parameter int d = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  keccak_chi_compress_if.slave bus,
  output logic                 busy,
  output logic [15:0]          row_cnt
);
  localparam int NE = (d + 1) * (d + 1);
  localparam int NC = d + 1;

  logic          v1;
  logic          v2;
  logic [NE-1:0] s1_ap;
  logic [NE-1:0] s1_bp;
  logic [NE-1:0] s1_cp;
  logic [NE-1:0] s1_dp;
  logic [NE-1:0] s1_ep;
  logic          s1_last;
  logic [NC-1:0] s2_a;
  logic [NC-1:0] s2_b;
  logic [NC-1:0] s2_c;
  logic [NC-1:0] s2_d;
  logic [NC-1:0] s2_e;
  logic          s2_last;

  logic          s2_adv;
  logic          s1_adv;
  logic          xfer_in;
  logic          xfer_out;
  logic          s2_load;

  // Output share i of a bit is the XOR of the d+1 consecutive expanded shares i*(d+1)..i*(d+1)+d.
  function automatic logic [NC-1:0] compress(input logic [NE-1:0] x);
    logic [NC-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) begin
      for (int j = 0; j < NC; j++) begin
        r[i] = r[i] ^ x[i*NC + j];
      end
    end
    return r;
  endfunction

  always_comb begin
    s2_adv   = !v2 || bus.out_ready;
    s1_adv   = !v1 || s2_adv;
    xfer_in  = bus.in_valid && s1_adv;
    xfer_out = v2 && bus.out_ready;
    s2_load  = s2_adv && v1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (s1_adv) v1 <= bus.in_valid;
      if (s2_adv) v2 <= v1;
    end
  end

  // S1 stores the expanded shares untouched; no share combining may happen before this flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ap   <= '0;
      s1_bp   <= '0;
      s1_cp   <= '0;
      s1_dp   <= '0;
      s1_ep   <= '0;
      s1_last <= 1'b0;
    end else if (xfer_in) begin
      s1_ap   <= bus.ap_i;
      s1_bp   <= bus.bp_i;
      s1_cp   <= bus.cp_i;
      s1_dp   <= bus.dp_i;
      s1_ep   <= bus.ep_i;
      s1_last <= bus.in_last;
    end
`ifdef KECCAK_CLR_AFTER_USE_EN
    else if (s2_load) begin
      s1_ap   <= '0;
      s1_bp   <= '0;
      s1_cp   <= '0;
      s1_dp   <= '0;
      s1_ep   <= '0;
      s1_last <= 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_a    <= '0;
      s2_b    <= '0;
      s2_c    <= '0;
      s2_d    <= '0;
      s2_e    <= '0;
      s2_last <= 1'b0;
    end else if (s2_load) begin
      s2_a    <= compress(s1_ap);
      s2_b    <= compress(s1_bp);
      s2_c    <= compress(s1_cp);
      s2_d    <= compress(s1_dp);
      s2_e    <= compress(s1_ep);
      s2_last <= s1_last;
    end
`ifdef KECCAK_CLR_AFTER_USE_EN
    else if (xfer_out) begin
      s2_a    <= '0;
      s2_b    <= '0;
      s2_c    <= '0;
      s2_d    <= '0;
      s2_e    <= '0;
      s2_last <= 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= 16'd0;
    end else if (xfer_out) begin
      row_cnt <= row_cnt + 16'd1;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = v2;
  assign bus.out_last  = s2_last;
  assign bus.a_o       = s2_a;
  assign bus.b_o       = s2_b;
  assign bus.c_o       = s2_c;
  assign bus.d_o       = s2_d;
  assign bus.e_o       = s2_e;
  assign busy          = v1 || v2;
endmodule

// File: tb/tb_keccak_chi_compress.sv
// Self-checking bench for keccak_chi_compress: directed and random rows checked against a
// two-slot occupancy model whose output shares are share-group parities.
module tb_keccak_chi_compress;
  localparam int D  = 5;
  localparam int NE = (D + 1) * (D + 1);
  localparam int NC = D + 1;

  typedef struct packed {
    logic [NE-1:0] a;
    logic [NE-1:0] b;
    logic [NE-1:0] c;
    logic [NE-1:0] d;
    logic [NE-1:0] e;
    logic          last;
  } row_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [15:0] row_cnt;

  keccak_chi_compress_if #(.d(D)) bus ();

  keccak_chi_compress #(.d(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .row_cnt (row_cnt)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          n_out;
  row_t        drv;
  logic        drv_valid;
  logic        drv_ready;
  logic        accepted;

  logic        m_v1;
  logic        m_v2;
  row_t        m_s1;
  row_t        m_s2;
  logic [15:0] m_cnt;

  // Each output share is the parity of its group of d+1 expanded shares.
  function automatic logic [NC-1:0] fold(input logic [NE-1:0] x);
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) begin
      r[i] = ($countones(x[i*NC +: NC]) % 2) == 1;
    end
    return r;
  endfunction

  function automatic row_t rand_row();
    row_t        r;
    logic [63:0] t;
    t = {$urandom(), $urandom()}; r.a = t[NE-1:0];
    t = {$urandom(), $urandom()}; r.b = t[NE-1:0];
    t = {$urandom(), $urandom()}; r.c = t[NE-1:0];
    t = {$urandom(), $urandom()}; r.d = t[NE-1:0];
    t = {$urandom(), $urandom()}; r.e = t[NE-1:0];
    r.last = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model to the next rising edge.
  task automatic applyStimulus();
    logic exp_rdy;
    logic adv2;
    logic adv1;
    @(negedge clk);
    bus.in_valid  = drv_valid;
    bus.in_last   = drv.last;
    bus.ap_i      = drv.a;
    bus.bp_i      = drv.b;
    bus.cp_i      = drv.c;
    bus.dp_i      = drv.d;
    bus.ep_i      = drv.e;
    bus.out_ready = drv_ready;
    #1;
    exp_rdy = !m_v1 || !m_v2 || drv_ready;
    checkOutput("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    checkOutput("out_valid", 64'(bus.out_valid), 64'(m_v2));
    checkOutput("busy", 64'(busy), 64'(m_v1 || m_v2));
    checkOutput("row_cnt", 64'(row_cnt), 64'(m_cnt));
    if (m_v2) begin
      checkOutput("a_o", 64'(bus.a_o), 64'(fold(m_s2.a)));
      checkOutput("b_o", 64'(bus.b_o), 64'(fold(m_s2.b)));
      checkOutput("c_o", 64'(bus.c_o), 64'(fold(m_s2.c)));
      checkOutput("d_o", 64'(bus.d_o), 64'(fold(m_s2.d)));
      checkOutput("e_o", 64'(bus.e_o), 64'(fold(m_s2.e)));
      checkOutput("out_last", 64'(bus.out_last), 64'(m_s2.last));
    end
    accepted = drv_valid && exp_rdy;
    if (m_v2 && drv_ready) begin
      m_cnt = m_cnt + 16'd1;
      n_out++;
    end
    adv2 = !m_v2 || drv_ready;
    adv1 = !m_v1 || adv2;
    if (adv2) begin
      if (m_v1) m_s2 = m_s1;
      m_v2 = m_v1;
    end
    if (adv1) begin
      if (drv_valid) m_s1 = drv;
      m_v1 = drv_valid;
    end
  endtask

  row_t        bp_rows [3];
  row_t        pat;
  logic [NC-1:0] hold_a;
  logic [15:0] start_cnt;
  int          idx;

  initial begin
    rst_n         = 1'b0;
    drv           = '0;
    drv_valid     = 1'b0;
    drv_ready     = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.ap_i      = '0;
    bus.bp_i      = '0;
    bus.cp_i      = '0;
    bus.dp_i      = '0;
    bus.ep_i      = '0;
    bus.out_ready = 1'b1;
    m_v1 = 1'b0; m_v2 = 1'b0; m_s1 = '0; m_s2 = '0; m_cnt = 16'd0; n_out = 0;
    hold_a = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_row_cnt", 64'(row_cnt), 64'd0);
    checkOutput("rst_out_last", 64'(bus.out_last), 64'd0);
    checkOutput("rst_a_o", 64'(bus.a_o), 64'd0);

    // All 36 shares of bit a set: every group has even parity.
    drv = '0; drv.a = '1; drv_valid = 1'b1; drv_ready = 1'b1;
    applyStimulus();
    drv_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("ones_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("ones_a", 64'(bus.a_o), 64'h00);
    checkOutput("ones_b", 64'(bus.b_o), 64'h00);
    checkOutput("ones_e", 64'(bus.e_o), 64'h00);

    // One set share per group of a, a single share in group 1 of b.
    pat = '0;
    for (int i = 0; i < NC; i++) pat.a[i*NC] = 1'b1;
    pat.b[7] = 1'b1;
    drv = pat; drv_valid = 1'b1;
    applyStimulus();
    drv_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("pat_a", 64'(bus.a_o), 64'h3F);
    checkOutput("pat_b", 64'(bus.b_o), 64'h02);
    checkOutput("pat_c", 64'(bus.c_o), 64'h00);

    // Ten back-to-back rows, only row 6 tagged last.
    start_cnt = m_cnt;
    n_out = 0;
    for (int k = 0; k < 10; k++) begin
      drv = rand_row();
      drv.last = (k == 6);
      drv_valid = 1'b1;
      applyStimulus();
      checkOutput("stream_accept", 64'(accepted), 64'd1);
    end
    drv_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("stream_n_out", 64'(n_out), 64'd10);
    applyStimulus();
    checkOutput("stream_row_cnt", 64'(row_cnt), 64'(start_cnt + 16'd10));

    // Backpressure: three rows offered while the consumer stalls for five cycles.
    for (int k = 0; k < 3; k++) bp_rows[k] = rand_row();
    idx = 0;
    drv_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drv_valid = (idx < 3);
      drv = bp_rows[(idx < 3) ? idx : 2];
      applyStimulus();
      if (accepted) idx++;
      if (c == 2) hold_a = bus.a_o;
      if (c == 4) begin
        checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("bp_a_stable", 64'(bus.a_o), 64'(hold_a));
      end
    end
    checkOutput("bp_accepted", 64'(idx), 64'd2);
    n_out = 0;
    drv_ready = 1'b1;
    for (int c = 0; c < 20 && n_out < 3; c++) begin
      drv_valid = (idx < 3);
      drv = bp_rows[(idx < 3) ? idx : 2];
      applyStimulus();
      if (accepted) idx++;
    end
    checkOutput("bp_delivered", 64'(n_out), 64'd3);
    checkOutput("bp_all_taken", 64'(idx), 64'd3);

    for (int c = 0; c < 300; c++) begin
      drv = rand_row();
      drv_valid = ($urandom_range(0, 3) != 0);
      drv_ready = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end

    // Reset with both stages full.
    drv_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drv = rand_row();
      drv_valid = 1'b1;
      applyStimulus();
    end
    checkOutput("pre_rst_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    drv_valid = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_row_cnt", 64'(row_cnt), 64'd0);
    m_v1 = 1'b0; m_v2 = 1'b0; m_cnt = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    for (int c = 0; c < 100; c++) begin
      drv = rand_row();
      drv_valid = ($urandom_range(0, 2) != 0);
      drv_ready = ($urandom_range(0, 2) != 0);
      applyStimulus();
    end

    // Single row then idle: watch what the registers keep after the row has moved on.
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    repeat (3) applyStimulus();
    drv = pat; drv.c = '1; drv.c[0] = 1'b0; drv.last = 1'b1; drv_valid = 1'b1;
    applyStimulus();
    drv_valid = 1'b0;
    applyStimulus();
    applyStimulus();
`ifdef KECCAK_CLR_AFTER_USE_EN
    checkOutput("clr_s1_ap", 64'(dut.s1_ap), 64'd0);
    checkOutput("clr_s1_cp", 64'(dut.s1_cp), 64'd0);
`endif
    applyStimulus();
`ifdef KECCAK_CLR_AFTER_USE_EN
    checkOutput("clr_a_o", 64'(bus.a_o), 64'd0);
    checkOutput("clr_b_o", 64'(bus.b_o), 64'd0);
    checkOutput("clr_c_o", 64'(bus.c_o), 64'd0);
    checkOutput("clr_out_last", 64'(bus.out_last), 64'd0);
`else
    checkOutput("stale_a_o", 64'(bus.a_o), 64'h3F);
    checkOutput("stale_b_o", 64'(bus.b_o), 64'h02);
    checkOutput("stale_c_o", 64'(bus.c_o), 64'h01);
`endif
    checkOutput("idle_out_valid", 64'(bus.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
